shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
Sequential unsigned WIDTH x WIDTH multiplier controller using the shift-and-add method. It sits directly upstream and downstream of the team's combinational ripple-carry adder. Each cycle it drives the adder's a/b/c_in inputs and captures its sum/c_out back into the accumulator. The adder is instantiated outside this block and wired through the add_* ports, so the same adder serves ALU and multiply datapaths.

Parameters:
WIDTH, 8, operand width; must equal the external adder width.
CNT_W, 4, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
multiplicand  input  WIDTH  operand M, captured on accepted start.
multiplier  input  WIDTH  operand Q, captured on accepted start.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse; product valid.
product  output  2*WIDTH  result; holds until the next accepted start.
add_a  output  WIDTH  to adder a: accumulator A.
add_b  output  WIDTH  to adder b: M when (state==RUN && Q[0]), else 0.
add_cin  output  1  to adder c_in; constant 0.
add_sum  input  WIDTH  from adder sum; combinational, same cycle.
add_cout  input  1  from adder c_out.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). rst takes priority over every other input.
- Reset values: state=IDLE, A=0, Q=0, M=0, cnt=0, product=0, busy=0, done=0.
- FSM states and transitions:
  - IDLE: if start=1, load M<=multiplicand, Q<=multiplier, A<=0, cnt<=0, then go to RUN.
  - RUN: each cycle, {A,Q} <= {add_cout, add_sum, Q} >> 1 (the 2*WIDTH+1-bit value shifted right by one). cnt<=cnt+1. When cnt==WIDTH-1, go to DONE.
  - DONE: product<={A,Q}, done=1 for this cycle only, then go to IDLE.
- Timing: with start sampled at the end of cycle 0, RUN occupies cycles 1..WIDTH and done is high in cycle WIDTH+1 (cycle 9 for WIDTH=8). product is registered and valid from cycle WIDTH+2 onward. done is registered, asserted on the DONE-state cycle. product is updated at the DONE->IDLE edge, so product is visible one cycle after done. The bench samples product while or after done falls.
- Adder inputs when Q[0]=0 in RUN: add_b=0, so add_sum=A and add_cout=0 (pure shift).
- start while busy (RUN or DONE) is ignored; operands are not re-sampled.
- Back-to-back: start in the first IDLE cycle after DONE is accepted. Minimum initiation interval is WIDTH+2 cycles.
- Reset mid-operation: the operation is aborted, done is never pulsed for it, and product returns to 0.
- Arithmetic: unsigned only. The carry out of each add is preserved in the shift, so no overflow is possible. The maximum result (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- Inputs multiplicand/multiplier may change freely after the accepted start.

Optional Feature:
ZERO_BYPASS_EN: when defined, an accepted start with multiplicand==0 or multiplier==0 goes IDLE->DONE directly. product=0 and done is high in cycle 1, giving latency 1. The add_* ports stay idle (add_b=0) throughout.
When undefined: zero operands take the full WIDTH RUN cycles like any other operands and still yield 0.

Test Plan:
- rst=1 for 2 cycles, then release -> busy=0, done=0, product=0x0000, add_b=0, add_cin=0.
- start with 0x0D x 0x0B -> done high exactly in cycle 9 after start; product=0x008F on the following cycle.
- start with 0xFF x 0xFF (carry into shift every iteration) -> product=0xFE01. During RUN, add_cout is observed =1 and shifted into A[7].
- start with 0x00 x 0x55 -> product=0x0000. done in cycle 9 with the macro undefined; done in cycle 1 with ZERO_BYPASS_EN.
- start 0x12 x 0x34, then start re-asserted with 0xFF x 0xFF during RUN -> ignored; product=0x03A8. A new start in the cycle after done is accepted.
- start 0x80 x 0x80, rst pulsed in RUN cycle 4 -> no done pulse; busy=0 and product=0 the next cycle. A fresh 0x80 x 0x80 then gives product=0x4000.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier controller.
// The ripple-carry adder sits outside this block and is reached through add_*.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           request, sampled only while idle
//   multiplicand    operand M, captured on an accepted start
//   multiplier      operand Q, captured on an accepted start
//   busy            high whenever the controller is not idle
//   done            one-cycle pulse, product becomes visible the next cycle
//   product         2*WIDTH result, held until the next completed operation
//   add_a/add_b     adder operands: accumulator A, and M gated by Q[0]
//   add_cin         adder carry-in, tied low
//   add_sum/add_cout combinational adder result, same cycle
//
// Optional build macro ZERO_BYPASS_EN: a start with either operand zero
// skips the iteration loop and finishes after a single cycle with product 0.

module shift_add_multiplier #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign add_a   = acc;
    assign add_b   = (state == S_RUN && mq[0]) ? mcand : '0;
    assign add_cin = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            acc     <= '0;
            mq      <= '0;
            mcand   <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        cnt   <= '0;
                        mcand <= multiplicand;
`ifdef ZERO_BYPASS_EN
                        if (multiplicand == '0 || multiplier == '0) begin
                            // Product is known to be zero; clear Q so the
                            // DONE-state capture of {A,Q} yields 0.
                            mq    <= '0;
                            state <= S_DONE;
                        end else begin
                            mq    <= multiplier;
                            state <= S_RUN;
                        end
`else
                        mq    <= multiplier;
                        state <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    // {cout, sum, Q} shifted right by one; the carry lands
                    // in the top bit of A so no partial product is lost.
                    acc <= {add_cout, add_sum[WIDTH-1:1]};
                    mq  <= {add_sum[0], mq[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    product <= {acc, mq};
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier.
// Models the external ripple-carry adder as a plain behavioural add.

module tb_shift_add_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;

    int checks   = 0;
    int failures = 0;

`ifdef ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 9;
`endif

    shift_add_multiplier #(.WIDTH(8), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_sum      (add_sum),
        .add_cout     (add_cout)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts one operation from an idle cycle, counts cycles to done,
    // then checks the product one cycle later.
    task automatic run_op(input string tag, input logic [7:0] m,
                          input logic [7:0] q, input logic [15:0] exp,
                          input int exp_lat, input bit inject,
                          output bit saw_cout);
        int  lat;
        int  bad;
        logic prev_cout;
        saw_cout  = 1'b0;
        bad       = 0;
        prev_cout = 1'b0;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        multiplicand = ~m;
        multiplier   = ~q;
        lat = 1;
        while (!done && lat < 40) begin
            if (busy !== 1'b1) bad++;
            if (add_cin !== 1'b0) bad++;
            if (prev_cout && add_a[7] !== 1'b1) bad++;
            if (add_cout === 1'b1) saw_cout = 1'b1;
            prev_cout = add_cout;
            if (inject) begin
                start        = (lat == 3);
                multiplicand = 8'hFF;
                multiplier   = 8'hFF;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        if (prev_cout && add_a[7] !== 1'b1) bad++;
        check({tag, "_done_cycle"}, lat, exp_lat);
        check({tag, "_run_ok"}, bad, 0);
        tick();
        check({tag, "_product"}, product, exp);
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_idle"}, {busy, add_b}, 9'd0);
    endtask

    initial begin
        bit cout_seen;
        int bad;
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = 8'h00;
        multiplier   = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_product", product, 16'h0000);
        check("rst_add_b", add_b, 8'h00);
        check("rst_add_cin", add_cin, 1'b0);

        run_op("m0d_0b", 8'h0D, 8'h0B, 16'h008F, 9, 1'b0, cout_seen);
        tick();
        run_op("mff_ff", 8'hFF, 8'hFF, 16'hFE01, 9, 1'b0, cout_seen);
        check("mff_ff_cout_seen", cout_seen, 1'b1);
        tick();
        run_op("m00_55", 8'h00, 8'h55, 16'h0000, ZERO_LAT, 1'b0, cout_seen);
        tick();
        run_op("m12_34", 8'h12, 8'h34, 16'h03A8, 9, 1'b1, cout_seen);
        // Immediately following idle cycle: start must be accepted.
        run_op("b2b_03_05", 8'h03, 8'h05, 16'h000F, 9, 1'b0, cout_seen);

        // Reset in RUN cycle 4 aborts the operation.
        multiplicand = 8'h80;
        multiplier   = 8'h80;
        start        = 1'b1;
        tick();
        start = 1'b0;
        bad = 0;
        for (int i = 1; i < 4; i++) begin
            if (done !== 1'b0) bad++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_product", product, 16'h0000);
        for (int i = 0; i < 12; i++) begin
            if (done !== 1'b0) bad++;
            tick();
        end
        check("abort_no_done", bad, 0);

        run_op("m80_80", 8'h80, 8'h80, 16'h4000, 9, 1'b0, cout_seen);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
